// File: rtl/regbank_pkg.sv
// Shared definitions for the 8x16 register bank and its port arbiters.
// Holds bank geometry, arbiter state encoding and a behavioural round-robin pick.
package regbank_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;
  localparam int RR_MAX_REQ = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Scans ptr, ptr+1, ... modulo nreq; descending loop lets the closest offset win.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input logic [2:0]            ptr,
                                       input int                    nreq);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        cand = (int'(ptr) + k) % nreq;
        if (req[cand]) begin
          res.found = 1'b1;
          res.idx   = 3'(cand);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, rotate back.
// Shared between the write-port arbiter and any future read-port arbiter.
module rr_priority_pick #(
  parameter  int NREQ  = 4,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic             o_found,
  output logic [PTR_W-1:0] o_idx,
  output logic [NREQ-1:0]  o_grant
);

  localparam logic [PTR_W:0] NREQ_W = (PTR_W + 1)'(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [PTR_W-1:0]  w_off;
  logic [PTR_W:0]    w_sum;

  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_ptr +: NREQ];

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PTR_W'(k);
    end
  end

  assign o_found = |w_rot;
  assign w_sum   = {1'b0, w_off} + {1'b0, i_ptr};
  assign o_idx   = (w_sum >= NREQ_W) ? PTR_W'(w_sum - NREQ_W) : w_sum[PTR_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_grant
      assign o_grant[gi] = o_found && (o_idx == PTR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write-port arbiter for the register bank with locked-burst support.
// ack is combinational; the granted write appears registered on wr_* one cycle later.
module regbank_wr_arbiter
  import regbank_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int DATA_W = REG_DATA_W,
  parameter  int ADDR_W = REG_ADDR_W,
  localparam int PTR_W  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_reg,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_reg,
  output logic [DATA_W-1:0]        wr_data,
  output logic [PTR_W-1:0]         owner,
  output logic                     locked
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [PTR_W-1:0]  r_own_id;
  logic [PTR_W-1:0]  w_own_next;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_reg;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_pick_found;
  logic [PTR_W-1:0]  w_pick_idx;
  logic [NREQ-1:0]   w_pick_grant;
  logic [NREQ-1:0]   w_ack;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic              w_xfer;

  logic [ADDR_W-1:0] w_reg_arr  [NREQ];
  logic [DATA_W-1:0] w_data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_reg_arr[gi]  = req_reg[gi*ADDR_W +: ADDR_W];
      assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  rr_priority_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx),
    .o_grant (w_pick_grant)
  );

  always_comb begin
    w_ack        = '0;
    w_gnt_idx    = r_own_id;
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_own_next   = r_own_id;

    if (r_state == ARB_OWNED) begin
      w_ack[r_own_id] = req[r_own_id];
    end else if (w_pick_found) begin
      w_ack     = w_pick_grant;
      w_gnt_idx = w_pick_idx;
    end

    // Grants are suppressed while reset is held, independent of the clock.
    if (!rst) w_ack = '0;
    w_xfer = |w_ack;

    if (w_xfer) begin
      if (req_lock[w_gnt_idx]) begin
        w_state_next = ARB_OWNED;
        w_own_next   = w_gnt_idx;
      end else begin
        w_state_next = ARB_IDLE;
        w_ptr_next   = inc_wrap(w_gnt_idx);
      end
    end else if (r_state == ARB_OWNED && !req[r_own_id]) begin
      w_state_next = ARB_IDLE;
      w_ptr_next   = inc_wrap(r_own_id);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_own_id  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_own_id <= w_own_next;
      r_wr_en  <= w_xfer;
      if (w_xfer) begin
        r_wr_reg  <= w_reg_arr[w_gnt_idx];
        r_wr_data <= w_data_arr[w_gnt_idx];
      end
    end
  end

  assign ack     = w_ack;
  assign wr_en   = r_wr_en;
  assign wr_reg  = r_wr_reg;
  assign wr_data = r_wr_data;
  assign owner   = r_own_id;
  assign locked  = (r_state == ARB_OWNED);

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench for regbank_wr_arbiter: expected grants and writes are queued by the
// stimulus process and consumed by a negedge monitor; a small bank model gives read-back.
module tb_regbank_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_lock;
  logic [11:0] req_reg_bus;
  logic [63:0] req_data_bus;
  logic [3:0]  ack;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [15:0] wr_data;
  logic [1:0]  owner;
  logic        locked;

  logic [2:0]  rq_reg  [4];
  logic [15:0] rq_data [4];
  logic [15:0] bank    [8];

  int          checks = 0;
  int          errors = 0;
  int          exp_ack_q [$];
  logic [18:0] exp_wr_q  [$];
  int          mon_idx;
  logic [18:0] mon_wr;
  logic [3:0]  mon_onehot;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pack
      assign req_reg_bus[gi*3 +: 3]   = rq_reg[gi];
      assign req_data_bus[gi*16 +: 16] = rq_data[gi];
    end
  endgenerate

  regbank_wr_arbiter #(
    .NREQ   (4),
    .DATA_W (16),
    .ADDR_W (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_lock (req_lock),
    .req_reg  (req_reg_bus),
    .req_data (req_data_bus),
    .ack      (ack),
    .wr_en    (wr_en),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .owner    (owner),
    .locked   (locked)
  );

  always @(posedge clk) begin
    if (wr_en) bank[wr_reg] <= wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_grant(input int idx);
    exp_ack_q.push_back(idx);
  endtask

  task automatic exp_write(input logic [2:0] r, input logic [15:0] d);
    exp_wr_q.push_back({r, d});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes one expected grant per ack and one expected write per wr_en.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (ack != 4'b0000) begin
        chk("ack_onehot", 32'($countones(ack)), 32'd1);
        chk("ack_without_req", {28'd0, ack & ~req}, 32'd0);
        if (exp_ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          mon_idx    = exp_ack_q.pop_front();
          mon_onehot = 4'b0001 << mon_idx;
          chk("ack_grant", {28'd0, ack}, {28'd0, mon_onehot});
        end
      end
      if (wr_en) begin
        $display("write reg=%0d data=%h", wr_reg, wr_data);
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got reg=%0d data=%h expected none", wr_reg, wr_data);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          chk("write_reg_data", {13'd0, wr_reg, wr_data}, {13'd0, mon_wr});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    req      = 4'b1111;
    req_lock = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rq_reg[i]  = 3'd0;
      rq_data[i] = 16'd0;
    end
    for (int i = 0; i < 8; i++) bank[i] = 16'd0;

    // Reset held with all requests active.
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", {28'd0, ack}, 32'd0);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_reg", {29'd0, wr_reg}, 32'd0);
      chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_owner", {30'd0, owner}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack", {28'd0, ack}, 32'd0);
      chk("idle_wr_en", {31'd0, wr_en}, 32'd0);
      chk("idle_wr_reg", {29'd0, wr_reg}, 32'd0);
      chk("idle_wr_data", {16'd0, wr_data}, 32'd0);
    end
    next_cycle();

    // Rotation: all four requesting, no lock.
    for (int i = 0; i < 4; i++) begin
      rq_reg[i]  = 3'(i);
      rq_data[i] = 16'(16'h0010 * (i + 1));
    end
    for (int k = 0; k < 8; k++) begin
      exp_grant(k % 4);
      exp_write(3'(k % 4), 16'(16'h0010 * ((k % 4) + 1)));
    end
    req = 4'b1111;
    repeat (8) next_cycle();
    req = 4'b0000;
    repeat (2) next_cycle();
    chk("bank_r0", {16'd0, bank[0]}, 32'h0010);
    chk("bank_r1", {16'd0, bank[1]}, 32'h0020);
    chk("bank_r2", {16'd0, bank[2]}, 32'h0030);
    chk("bank_r3", {16'd0, bank[3]}, 32'h0040);

    // Locked burst from requester 2; 0 and 1 keep requesting after it wins.
    req      = 4'b0100;
    req_lock = 4'b0100;
    rq_reg[2] = 3'd5; rq_data[2] = 16'hAAAA;
    exp_grant(2); exp_write(3'd5, 16'hAAAA);
    next_cycle();
    req = 4'b0111;
    rq_reg[2] = 3'd6; rq_data[2] = 16'hBBBB;
    exp_grant(2); exp_write(3'd6, 16'hBBBB);
    @(negedge clk);
    chk("burst_locked_1", {31'd0, locked}, 32'd1);
    chk("burst_owner_1", {30'd0, owner}, 32'd2);
    next_cycle();
    rq_reg[2] = 3'd7; rq_data[2] = 16'hCCCC;
    exp_grant(2); exp_write(3'd7, 16'hCCCC);
    @(negedge clk);
    chk("burst_locked_2", {31'd0, locked}, 32'd1);
    chk("burst_owner_2", {30'd0, owner}, 32'd2);
    next_cycle();
    req_lock = 4'b0000;
    rq_reg[2] = 3'd4; rq_data[2] = 16'hDDDD;
    exp_grant(2); exp_write(3'd4, 16'hDDDD);
    @(negedge clk);
    chk("burst_locked_3", {31'd0, locked}, 32'd1);
    next_cycle();
    req = 4'b0011;
    exp_grant(0); exp_write(3'd0, 16'h0010);
    @(negedge clk);
    chk("burst_released", {31'd0, locked}, 32'd0);
    next_cycle();
    exp_grant(1); exp_write(3'd1, 16'h0020);
    next_cycle();
    req = 4'b0000;
    next_cycle();

    // Burst abandon: requester 1 locks, then drops req while 3 requests.
    req      = 4'b0010;
    req_lock = 4'b0010;
    rq_reg[1] = 3'd2; rq_data[1] = 16'h1234;
    exp_grant(1); exp_write(3'd2, 16'h1234);
    next_cycle();
    req      = 4'b1000;
    req_lock = 4'b0000;
    rq_reg[3] = 3'd3; rq_data[3] = 16'h3333;
    exp_grant(3); exp_write(3'd3, 16'h3333);
    @(negedge clk);
    chk("abandon_ack_gap", {28'd0, ack}, 32'd0);
    chk("abandon_locked_before", {31'd0, locked}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("abandon_next_ack", {28'd0, ack}, 32'b1000);
    chk("abandon_locked_after", {31'd0, locked}, 32'd0);
    next_cycle();
    req = 4'b0000;
    next_cycle();

    // Same-register collision: later grant must win in the bank.
    rq_reg[0] = 3'd3; rq_data[0] = 16'h1111;
    rq_reg[1] = 3'd3; rq_data[1] = 16'h2222;
    exp_grant(0); exp_write(3'd3, 16'h1111);
    exp_grant(1); exp_write(3'd3, 16'h2222);
    req = 4'b0011;
    repeat (2) next_cycle();
    req = 4'b0000;
    repeat (2) next_cycle();
    chk("collision_r3", {16'd0, bank[3]}, 32'h2222);

    // Reset mid-burst: second locked grant is discarded by reset.
    req      = 4'b0100;
    req_lock = 4'b0100;
    rq_reg[2] = 3'd6; rq_data[2] = 16'h5555;
    exp_grant(2); exp_write(3'd6, 16'h5555);
    next_cycle();
    exp_grant(2);
    @(negedge clk);
    chk("midrst_locked_pre", {31'd0, locked}, 32'd1);
    chk("midrst_wr_en_pre", {31'd0, wr_en}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    chk("midrst_ack", {28'd0, ack}, 32'd0);
    chk("midrst_owner", {30'd0, owner}, 32'd0);
    next_cycle();
    rst      = 1'b1;
    req      = 4'b1111;
    req_lock = 4'b0000;
    rq_reg[0] = 3'd0; rq_data[0] = 16'h0F0F;
    exp_grant(0); exp_write(3'd0, 16'h0F0F);
    @(negedge clk);
    chk("post_rst_first_ack", {28'd0, ack}, 32'b0001);
    next_cycle();
    req = 4'b0000;
    repeat (3) next_cycle();

    chk("pending_grants", 32'(exp_ack_q.size()), 32'd0);
    chk("pending_writes", 32'(exp_wr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_wr_arbiter.md
# regbank_wr_arbiter

Round-robin arbiter that shares the single write port of the 8×16-bit register bank between NREQ independent requesters. It sits directly in front of the bank's wr_en/wr_reg/wr_data inputs. It accepts at most one write per cycle with a valid/ack handshake, and supports locked bursts so one requester can issue back-to-back writes without interleaving.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_W, 16, write data width (matches bank)
- ADDR_W, 3, register index width (matches bank)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester write request
- req_lock  in  NREQ  per-requester burst lock, sampled with req
- req_reg  in  NREQ*ADDR_W  packed register indices, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
- ack  out  NREQ  combinational one-hot grant; write transfers at the edge ending a cycle with ack[i]=1
- wr_en  out  1  registered write enable to bank
- wr_reg  out  ADDR_W  registered register index to bank
- wr_data  out  DATA_W  registered write data to bank
- owner  out  $clog2(NREQ)  requester currently holding the lock (valid when locked=1)
- locked  out  1  arbiter in OWNED state

## Operation
- State: ptr (highest-priority requester), fsm {IDLE, OWNED}, own_id.
- IDLE: ack goes to the first i with req[i]=1, scanning ptr, ptr+1, … NREQ-1, 0, … ptr-1 (wrap modulo NREQ).
- OWNED: only own_id may be acked. ack[own_id]=req[own_id]. All other requests stall.
- On a transfer from requester g:
  - wr_en←1, wr_reg←req_reg[g], wr_data←req_data[g].
  - If req_lock[g]=1: fsm←OWNED, own_id←g, ptr unchanged.
  - If req_lock[g]=0: fsm←IDLE, ptr←(g+1) mod NREQ.
- No transfer in a cycle: wr_en←0. wr_reg and wr_data hold their last values.
- OWNED with req[own_id]=0 (requester abandons the burst): fsm←IDLE, ptr←(own_id+1) mod NREQ at that edge. ack is all zero in that cycle.
- The handshake requires requesters to hold req, req_lock, req_reg and req_data stable until the cycle in which ack is seen. The arbiter never withdraws ack within a cycle.
- ack is at most one-hot and never asserted for a requester with req=0.
- Two requesters may target the same register in consecutive cycles. Writes commit in grant order, so the later write wins.

## Timing
- Reset (rst=0, asynchronous): wr_en=0, wr_reg=0, wr_data=0, ptr=0, fsm=IDLE, own_id=0, locked=0, owner=0. ack is forced to 0 while rst=0.
- Reset asserted mid-burst drops the lock. A write registered in wr_* is discarded because wr_en clears immediately.
- Latency:
  - Cycle k: ack[i]=1.
  - Cycle k+1: wr_en=1 with that requester's index and data.
  - Edge ending k+1: bank commits.
  - Read-back through the bank is visible from cycle k+2.
- Throughput: one write per cycle sustained.
  - N requesters all requesting without lock receive grants strictly rotating, one per cycle.
  - No requester waits more than NREQ-1 cycles while no lock is held.
- locked and owner are registered and reflect fsm/own_id.

## Structure
- Shared package regbank_pkg holds:
  - REG_ADDR_W=3 and REG_DATA_W=16, shared with the register bank.
  - A function rr_pick(req, ptr) returning the winning index and a found flag.
- Sub-module rr_priority_pick: purely combinational rotate / priority-encode / rotate-back. It is reusable for a future read-port arbiter.
- Top level holds the FSM, ptr, and output registers. Target 150–250 lines.

## Test plan
- Reset and idle:
  - Stimulus: hold rst=0 for 2 cycles with req=4'b1111, then release with req=0.
  - Required: ack=0 and wr_en=0 throughout; wr_reg=0 and wr_data=0.
- Rotation:
  - Stimulus: req=4'b1111, no lock, requester i sends reg=i and data=16'h0010*(i+1), held for 8 cycles.
  - Required: ack sequence 0,1,2,3,0,1,2,3. wr_* lags ack by one cycle. Bank read-back gives r0=0010, r1=0020, r2=0030, r3=0040.
- Locked burst:
  - Stimulus: requester 2 with lock=1 for 3 writes (r5←AAAA, r6←BBBB, r7←CCCC), then lock=0 on the 4th write (r4←DDDD), while requesters 0 and 1 request continuously.
  - Required: four consecutive acks to 2 with locked=1 and owner=2. The next ack goes to 3 if it is requesting, otherwise to 0.
- Burst abandon:
  - Stimulus: requester 1 is locked, then drops req while requester 3 requests.
  - Required: one cycle with ack=0 and locked→0. The next cycle acks requester 3 (ptr=2 → first active is 3).
- Same-register collision:
  - Stimulus: requesters 0 and 1 both target r3, with data 1111 and 2222.
  - Required: r3 reads 2222 after both commit.
- Reset mid-burst:
  - Stimulus: assert rst while locked=1 and wr_en=1.
  - Required: wr_en, locked and ack drop immediately without waiting for a clock; after release, grants restart from requester 0.
